// File: rtl/fifo_stream_adapter.sv
// Read-side FIFO consumer. It issues FIFO reads, absorbs the 1-cycle read latency and
// re-presents the words as a valid/ready stream through a 2-entry skid buffer.
module fifo_stream_adapter #(
   parameter int FIFO_WIDTH = 16,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [FIFO_WIDTH-1:0] fifo_data_out,
   input  logic                  fifo_empty,
   output logic                  fifo_rd_en,
   input  logic                  flush,
   output logic [FIFO_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [CNT_WIDTH-1:0]  rd_count,
   output logic                  busy
);

   logic [1:0]            occ;
   logic [1:0]            occ_post;
   logic                  pend;
   logic                  pop;
   logic [FIFO_WIDTH-1:0] slot0;
   logic [FIFO_WIDTH-1:0] slot1;
   logic [CNT_WIDTH-1:0]  cnt;

   assign m_valid  = (occ != 2'd0);
   assign m_data   = slot0;
   assign rd_count = cnt;
   assign busy     = m_valid | pend;
   assign pop      = m_valid & m_ready;

   // Occupancy after this cycle's pop; a pop only happens with occ>0, so no underflow.
   assign occ_post = occ - {1'b0, pop};

   // Reserve a slot for every word already in flight, so the skid can never overrun.
   assign fifo_rd_en = rst_n & ~fifo_empty & ~flush & ((occ_post + {1'b0, pend}) < 2'd2);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ   <= 2'd0;
         pend  <= 1'b0;
         slot0 <= '0;
         slot1 <= '0;
         cnt   <= '0;
      end else if (flush) begin
         occ  <= 2'd0;
         pend <= 1'b0;
      end else begin
         pend <= fifo_rd_en;
         occ  <= occ_post + {1'b0, pend};
         if (pop && occ == 2'd2)
            slot0 <= slot1;
         // Arrival lands in the first free slot once the pop has been applied.
         if (pend) begin
            if (occ_post == 2'd0)
               slot0 <= fifo_data_out;
            else
               slot1 <= fifo_data_out;
         end
         if (pop)
            cnt <= cnt + CNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_fifo_stream_adapter.sv
// Bench for fifo_stream_adapter: a FIFO model feeds the DUT, and a queue-based reference
// of in-flight and buffered words predicts every stream output cycle by cycle.
module tb_fifo_stream_adapter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] fifo_data_out;
   logic        fifo_empty;
   logic        fifo_rd_en;
   logic        flush;
   logic [15:0] m_data;
   logic        m_valid;
   logic        m_ready;
   logic [15:0] rd_count;
   logic        busy;

   logic        fifo_rd_en4;
   logic [15:0] m_data4;
   logic        m_valid4;
   logic [3:0]  rd_count4;
   logic        busy4;

   always #5 clk = ~clk;

   fifo_stream_adapter #(.FIFO_WIDTH(16), .CNT_WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n), .fifo_data_out(fifo_data_out), .fifo_empty(fifo_empty),
      .fifo_rd_en(fifo_rd_en), .flush(flush), .m_data(m_data), .m_valid(m_valid),
      .m_ready(m_ready), .rd_count(rd_count), .busy(busy));

   fifo_stream_adapter #(.FIFO_WIDTH(16), .CNT_WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .fifo_data_out(fifo_data_out), .fifo_empty(fifo_empty),
      .fifo_rd_en(fifo_rd_en4), .flush(flush), .m_data(m_data4), .m_valid(m_valid4),
      .m_ready(m_ready), .rd_count(rd_count4), .busy(busy4));

   int          n_chk = 0;
   int          n_err = 0;
   logic [15:0] fifo_q[$];
   logic [15:0] buf_q[$];
   logic        infl;
   logic [15:0] infl_d;
   int          cnt;
   int          reads;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      buf_q.delete();
      infl  = 1'b0;
      infl_d = '0;
      cnt   = 0;
   endtask

   // One clock cycle: drive inputs, check outputs mid-cycle, advance the reference at posedge.
   task automatic step(input logic rdy, input logic fl);
      logic        exp_v, pop, exp_rd, rd_s, got;
      logic [15:0] nd;
      m_ready    = rdy;
      flush      = fl;
      fifo_empty = (fifo_q.size() == 0);
      @(negedge clk);
      exp_v  = (buf_q.size() != 0);
      pop    = exp_v & rdy;
      exp_rd = !fifo_empty && !fl && ((buf_q.size() + int'(infl) - int'(pop)) < 2);
      chk("m_valid", 32'(m_valid), 32'(exp_v));
      chk("m_valid4", 32'(m_valid4), 32'(exp_v));
      if (exp_v) begin
         chk("m_data", 32'(m_data), 32'(buf_q[0]));
         chk("m_data4", 32'(m_data4), 32'(buf_q[0]));
      end
      chk("busy", 32'(busy), 32'(exp_v | infl));
      chk("busy4", 32'(busy4), 32'(exp_v | infl));
      chk("rd_count", 32'(rd_count), cnt % 65536);
      chk("rd_count4", 32'(rd_count4), cnt % 16);
      chk("fifo_rd_en", 32'(fifo_rd_en), 32'(exp_rd));
      chk("fifo_rd_en4", 32'(fifo_rd_en4), 32'(exp_rd));
      rd_s = fifo_rd_en;
      if (rd_s) reads++;
      @(posedge clk);
      got = 1'b0;
      nd  = '0;
      if (rd_s && fifo_q.size() != 0) begin
         nd  = fifo_q.pop_front();
         got = 1'b1;
      end
      if (fl) begin
         buf_q.delete();
         infl = 1'b0;
      end else begin
         if (pop) begin
            void'(buf_q.pop_front());
            cnt++;
         end
         if (infl) buf_q.push_back(infl_d);
         infl   = got;
         infl_d = nd;
      end
      #1;
      if (got) fifo_data_out = nd;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #3;
      model_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; m_ready = 1'b0; fifo_empty = 1'b0; fifo_data_out = 16'h0;
      model_reset();
      #2;
      // Reset state; rd_en must stay low even though the FIFO claims data.
      chk("rst_m_valid", 32'(m_valid), 0);
      chk("rst_m_data", 32'(m_data), 0);
      chk("rst_rd_count", 32'(rd_count), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_rd_en", 32'(fifo_rd_en), 0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Streaming at full rate.
      for (int i = 1; i <= 8; i++) fifo_q.push_back(16'(i));
      reads = 0;
      for (int i = 0; i < 12; i++) step(1'b1, 1'b0);
      chk("stream_reads", 32'(reads), 8);
      chk("stream_count", 32'(rd_count), 8);

      // Backpressure: only two reads may be outstanding.
      for (int i = 1; i <= 8; i++) fifo_q.push_back(16'(i));
      reads = 0;
      for (int i = 0; i < 6; i++) step(1'b0, 1'b0);
      chk("bp_reads", 32'(reads), 2);
      chk("bp_hold", 32'(m_data), 32'h1);
      for (int i = 0; i < 14; i++) step(1'b1, 1'b0);
      chk("bp_count", 32'(rd_count), 16);
      chk("bp_drained", 32'(m_valid), 0);

      // Empty FIFO with toggling ready.
      for (int i = 0; i < 20; i++) step(1'(i & 1), 1'b0);

      // Flush with 0xAA buffered and 0xBB in flight.
      fifo_q.push_back(16'h00AA);
      step(1'b0, 1'b0);
      fifo_q.push_back(16'h00BB);
      fifo_q.push_back(16'h00CC);
      step(1'b0, 1'b0);
      chk("fl_pre_data", 32'(m_data), 32'h00AA);
      step(1'b0, 1'b1);
      chk("fl_valid", 32'(m_valid), 0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
      chk("fl_next", 32'(m_data), 32'h00CC);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0);

      // Randomized traffic with occasional flushes.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(2) == 0 && fifo_q.size() < 8) fifo_q.push_back(16'($urandom));
         step(1'($urandom_range(3) != 0), 1'($urandom_range(19) == 0));
      end
      fifo_q.delete();
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0);

      // Counter wrap on the 4-bit instance.
      do_reset();
      for (int i = 0; i < 17; i++) fifo_q.push_back(16'(16'h100 + i));
      for (int i = 0; i < 22; i++) step(1'b1, 1'b0);
      chk("wrap_count4", 32'(rd_count4), 1);
      chk("wrap_count16", 32'(rd_count), 17);

      // Asynchronous reset with both slots full.
      do_reset();
      for (int i = 1; i <= 4; i++) fifo_q.push_back(16'(16'h200 + i));
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
      chk("pre_rst_busy", 32'(busy), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_m_valid", 32'(m_valid), 0);
      chk("arst_m_data", 32'(m_data), 0);
      chk("arst_rd_count", 32'(rd_count), 0);
      chk("arst_busy", 32'(busy), 0);
      chk("arst_rd_en", 32'(fifo_rd_en), 0);
      model_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0);
      chk("post_rst_count", 32'(rd_count), 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule
